search_sequencer: RTL and testbench

Sequences one NLFSR tap-search session: clears the PRNG, selector and NLFSR, lets the selector draw a tap set, runs the NLFSR on it, and reruns with fresh taps on each failure. It stops when a full-period configuration is found, the attempt budget runs out, or the session is aborted. It sits above the generator/selector/feedback/NLFSR datapath and drives its reset and enables, latching the winning tap vector for the host.

---
 rtl/search_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_search_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/search_sequencer.sv
// search_sequencer
//   Sequences one NLFSR tap-search session. Each attempt clears the
//   PRNG/selector/NLFSR (CLEAR), lets the selector draw a tap set (GEN), then
//   runs the NLFSR on it (RUN). A failure triggers a fresh attempt until the
//   attempt budget is used up. A full-period result, an exhausted budget or an
//   abort ends the session with a one-cycle done pulse (REPORT).
//
// Optional feature macro: SEARCH_TIMEOUT_EN
//   When defined, a RUN-phase watchdog treats a RUN lasting TIMEOUT_CYCLES
//   cycles without any NLFSR response as a failure.
//
// Ports
//   clk           clock
//   res           synchronous active-high reset
//   start         begin a session (sampled in IDLE only)
//   abort         end the session early (sampled in CLEAR/GEN/RUN)
//   sub_res       reset to PRNG/selector/NLFSR (res or CLEAR)
//   gen_ena       PRNG enable (GEN)
//   sel_done      selector finished a tap set
//   taps          tap vector from the selector
//   nlfsr_ena     NLFSR enable (RUN)
//   nlfsr_found   NLFSR completed a full period
//   nlfsr_failure NLFSR hit a short cycle
//   busy          session in progress
//   done          one-cycle end-of-session pulse
//   found         session found a full-period tap set
//   exhausted     session used up its attempt budget
//   found_taps    winning tap vector
//   attempts      failed attempts in this session
module search_sequencer #(
  parameter int NUM_OF_TAPS    = 15,
  parameter int ATT_W          = 16,
  parameter int MAX_ATTEMPTS   = 1000,
  parameter int TIMEOUT_CYCLES = 70000
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic                     abort,
  output logic                     sub_res,
  output logic                     gen_ena,
  input  logic                     sel_done,
  input  logic [NUM_OF_TAPS*8-1:0] taps,
  output logic                     nlfsr_ena,
  input  logic                     nlfsr_found,
  input  logic                     nlfsr_failure,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic                     exhausted,
  output logic [NUM_OF_TAPS*8-1:0] found_taps,
  output logic [ATT_W-1:0]         attempts
);

  localparam int TW = NUM_OF_TAPS * 8;

  // Elaboration-time parameter sanity checks.
  if (MAX_ATTEMPTS < 1 || longint'(MAX_ATTEMPTS) > ((64'd1 << ATT_W) - 64'd1)) begin : g_chk_att
    $error("MAX_ATTEMPTS must be in 1..2^ATT_W-1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_to
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GEN,
    RUN,
    REPORT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TW-1:0]     tap_reg;
  logic [ATT_W-1:0]  att_inc;
  logic              fail_evt;
  logic              budget_out;

`ifdef SEARCH_TIMEOUT_EN
  localparam int RC_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [RC_W-1:0] run_cnt;

  // Counts RUN cycles of the current attempt; cleared when the tap set is taken.
  always_ff @(posedge clk) begin
    if (res) begin
      run_cnt <= '0;
    end else if (state == GEN && sel_done) begin
      run_cnt <= '0;
    end else if (state == RUN) begin
      run_cnt <= run_cnt + RC_W'(1);
    end
  end

  // The last permitted RUN cycle without a response counts as a failure.
  always_comb begin
    fail_evt = nlfsr_failure || (run_cnt == RC_W'(TIMEOUT_CYCLES - 1));
  end
`else
  always_comb begin
    fail_evt = nlfsr_failure;
  end
`endif

  always_comb begin
    att_inc    = attempts + ATT_W'(1);
    budget_out = (att_inc == ATT_W'(MAX_ATTEMPTS));
  end

  // Next-state logic. abort outranks everything in CLEAR/GEN/RUN; in RUN a
  // found result outranks a (real or watchdog) failure.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = abort ? REPORT : GEN;
      GEN: begin
        if (abort)         state_nxt = REPORT;
        else if (sel_done) state_nxt = RUN;
      end
      RUN: begin
        if (abort)            state_nxt = REPORT;
        else if (nlfsr_found) state_nxt = REPORT;
        else if (fail_evt)    state_nxt = budget_out ? REPORT : CLEAR;
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs; sub_res additionally follows res directly.
  always_comb begin
    sub_res   = res || (state == CLEAR);
    gen_ena   = (state == GEN);
    nlfsr_ena = (state == RUN);
    busy      = (state != IDLE);
    done      = (state == REPORT);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      tap_reg    <= '0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      found_taps <= '0;
      attempts   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_taps <= '0;
            attempts   <= '0;
          end
        end
        CLEAR: begin
          if (abort) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
          end
        end
        GEN: begin
          if (abort) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
          end else if (sel_done) begin
            tap_reg <= taps;
          end
        end
        RUN: begin
          if (abort) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
          end else if (nlfsr_found) begin
            found_taps <= tap_reg;
            found      <= 1'b1;
          end else if (fail_evt) begin
            attempts <= att_inc;
            if (budget_out) exhausted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_search_sequencer.sv
module tb_search_sequencer;

  localparam int NT   = 15;
  localparam int TW   = NT * 8;
  localparam int AW   = 16;
  localparam int MAXA = 3;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sel_done = 1'b0;
  logic          nlfsr_found = 1'b0;
  logic          nlfsr_failure = 1'b0;
  logic [TW-1:0] taps = '0;
  logic          sub_res, gen_ena, nlfsr_ena, busy, done, found, exhausted;
  logic [TW-1:0] found_taps;
  logic [AW-1:0] attempts;

  always #5 clk = ~clk;

  search_sequencer #(
    .NUM_OF_TAPS(NT),
    .ATT_W(AW),
    .MAX_ATTEMPTS(MAXA),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .res(res), .start(start), .abort(abort),
    .sub_res(sub_res), .gen_ena(gen_ena), .sel_done(sel_done), .taps(taps),
    .nlfsr_ena(nlfsr_ena), .nlfsr_found(nlfsr_found), .nlfsr_failure(nlfsr_failure),
    .busy(busy), .done(done), .found(found), .exhausted(exhausted),
    .found_taps(found_taps), .attempts(attempts)
  );

  // Session phases as the specification names them (bench-side bookkeeping).
  typedef enum int {P_IDLE, P_CLEAR, P_GEN, P_RUN, P_REPORT} ph_t;
  // How an attempt ends.
  typedef enum int {K_FOUND, K_FAIL, K_BOTH, K_ABORT_CLEAR, K_ABORT_GEN,
                    K_ABORT_RUN, K_TIMEOUT, K_RESET} kind_t;

  typedef struct {
    kind_t         k;
    int            g;   // GEN cycles before the sel_done cycle
    int            r;   // RUN cycles before the response cycle
    logic [TW-1:0] tp;
    logic          sr;  // pulse start in first RUN cycle
  } att_t;

  typedef struct {
    logic          sub_res, gen_ena, nlfsr_ena, busy, done, found, exhausted;
    logic [TW-1:0] ftaps;
    logic [AW-1:0] att;
    int            cyc;
  } exp_t;

  typedef enum int {S_FOUND, S_EXH, S_ATT, S_FTAPS, S_CLR, S_GENR, S_RUNC, S_BUSY} sig_e;
  typedef struct {
    sig_e         s;
    logic [127:0] v;
    string        name;
  } lit_t;

  exp_t eq[$];
  lit_t lq[$];
  att_t script[$];

  // Model of the held session results, as visible in the current cycle.
  logic          m_found = 1'b0, m_exh = 1'b0;
  logic [TW-1:0] m_ftaps = '0;
  int            m_att = 0;
  int            cyc = 0;

  int passed = 0;
  int total  = 0;

  // Event counters observed on the DUT outputs.
  int   clr_cnt = 0, gen_rise = 0, run_cyc = 0;
  logic prev_gen = 1'b0;

  always @(negedge clk) begin
    prev_gen <= gen_ena;
    if (sub_res && !res)     clr_cnt  <= clr_cnt + 1;
    if (gen_ena && !prev_gen) gen_rise <= gen_rise + 1;
    if (nlfsr_ena)           run_cyc  <= run_cyc + 1;
  end

  function automatic logic [TW-1:0] noise();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[TW-1:0];
  endfunction

  function automatic logic [127:0] sig_val(input sig_e s);
    case (s)
      S_FOUND: return 128'(found);
      S_EXH:   return 128'(exhausted);
      S_ATT:   return 128'(attempts);
      S_FTAPS: return 128'(found_taps);
      S_CLR:   return 128'(clr_cnt);
      S_GENR:  return 128'(gen_rise);
      S_RUNC:  return 128'(run_cyc);
      default: return 128'(busy);
    endcase
  endfunction

  task automatic chk(input string name, input int c, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got %h expected %h", name, c, act, exp);
  endtask

  // Single compare process: per-cycle model expectations plus literal pins.
  always @(negedge clk) begin
    exp_t e;
    lit_t l;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      chk("sub_res",    e.cyc, 128'(sub_res),    128'(e.sub_res));
      chk("gen_ena",    e.cyc, 128'(gen_ena),    128'(e.gen_ena));
      chk("nlfsr_ena",  e.cyc, 128'(nlfsr_ena),  128'(e.nlfsr_ena));
      chk("busy",       e.cyc, 128'(busy),       128'(e.busy));
      chk("done",       e.cyc, 128'(done),       128'(e.done));
      chk("found",      e.cyc, 128'(found),      128'(e.found));
      chk("exhausted",  e.cyc, 128'(exhausted),  128'(e.exhausted));
      chk("found_taps", e.cyc, 128'(found_taps), 128'(e.ftaps));
      chk("attempts",   e.cyc, 128'(attempts),   128'(e.att));
    end
    while (lq.size() > 0) begin
      l = lq.pop_front();
      chk(l.name, -1, sig_val(l.s), l.v);
    end
  end

  task automatic lit(input sig_e s, input logic [127:0] v, input string name);
    lit_t l;
    l.s = s; l.v = v; l.name = name;
    lq.push_back(l);
  endtask

  // One clock cycle: drive inputs sampled at the next edge and record what the
  // outputs must show during this cycle.
  task automatic step(input ph_t ph, input logic r, input logic st, input logic ab,
                      input logic sd, input logic nf, input logic nfl,
                      input logic [TW-1:0] tp);
    exp_t e;
    @(posedge clk);
    #1;
    res = r; start = st; abort = ab; sel_done = sd;
    nlfsr_found = nf; nlfsr_failure = nfl; taps = tp;
    e.sub_res   = r || (ph == P_CLEAR);
    e.gen_ena   = (ph == P_GEN);
    e.nlfsr_ena = (ph == P_RUN);
    e.busy      = (ph != P_IDLE);
    e.done      = (ph == P_REPORT);
    e.found     = m_found;
    e.exhausted = m_exh;
    e.ftaps     = m_ftaps;
    e.att       = AW'(m_att);
    e.cyc       = cyc;
    cyc++;
    eq.push_back(e);
  endtask

  task automatic idle();
    step(P_IDLE, 0, 0, 0, 0, 0, 0, noise());
  endtask

  // start/abort/response inputs in REPORT must all be ignored.
  task automatic report();
    step(P_REPORT, 0, 1, 1, 1, 1, 1, noise());
  endtask

  task automatic attempt(input att_t a, output logic more);
    int n;
    more = 1'b0;
    if (a.k == K_ABORT_CLEAR) begin
      step(P_CLEAR, 0, 0, 1, 1, 0, 0, noise());
      m_found = 1'b0; m_exh = 1'b0;
      report();
      return;
    end
    step(P_CLEAR, 0, 0, 0, 0, 0, 0, noise());
    for (int j = 0; j < a.g; j++) step(P_GEN, 0, 0, 0, 0, 0, 0, noise());
    if (a.k == K_RESET) begin
      step(P_GEN, 1, 0, 0, 1, 0, 0, a.tp);
      m_found = 1'b0; m_exh = 1'b0; m_att = 0; m_ftaps = '0;
      return;
    end
    if (a.k == K_ABORT_GEN) begin
      step(P_GEN, 0, 0, 1, 1, 0, 0, a.tp);
      m_found = 1'b0; m_exh = 1'b0;
      report();
      return;
    end
    step(P_GEN, 0, 0, 0, 1, 0, 0, a.tp);
    n = (a.k == K_TIMEOUT) ? TO : a.r + 1;
    for (int j = 0; j < n; j++) begin
      logic last;
      last = (j == n - 1);
      step(P_RUN, 0, a.sr && (j == 0), last && (a.k == K_ABORT_RUN), 0,
           last && (a.k == K_FOUND || a.k == K_BOTH),
           last && (a.k == K_FAIL || a.k == K_BOTH), noise());
    end
    case (a.k)
      K_FOUND, K_BOTH: begin
        m_found = 1'b1; m_ftaps = a.tp;
        report();
      end
      K_ABORT_RUN: begin
        m_found = 1'b0; m_exh = 1'b0;
        report();
      end
      default: begin
        m_att++;
        if (m_att == MAXA) begin
          m_exh = 1'b1;
          report();
        end else begin
          more = 1'b1;
        end
      end
    endcase
  endtask

  task automatic session();
    logic more;
    att_t a;
    step(P_IDLE, 0, 1, 0, 0, 0, 0, noise());
    m_found = 1'b0; m_exh = 1'b0; m_att = 0; m_ftaps = '0;
    more = 1'b1;
    while (more && script.size() > 0) begin
      a = script.pop_front();
      attempt(a, more);
    end
    script.delete();
    idle();
    idle();
  endtask

  task automatic add(input kind_t k, input int g, input int r,
                     input logic [TW-1:0] tp, input logic sr);
    att_t a;
    a.k = k; a.g = g; a.r = r; a.tp = tp; a.sr = sr;
    script.push_back(a);
  endtask

  initial begin
    logic [TW-1:0] t_a5, t1, t2, t3;
    int b_clr, b_gen, b_run;
    t_a5 = {NT{8'hA5}};
    t1   = {NT{8'h3C}};
    t2   = {NT{8'h81}};
    t3   = {NT{8'h5E}};

    // Reset: two cycles with res high, then idle.
    step(P_IDLE, 1, 0, 0, 0, 0, 0, noise());
    step(P_IDLE, 1, 1, 0, 0, 0, 0, noise());
    idle();
    lit(S_FOUND, 128'd0, "rst_found");
    lit(S_ATT,   128'd0, "rst_attempts");
    lit(S_FTAPS, 128'd0, "rst_found_taps");
    lit(S_BUSY,  128'd0, "rst_busy");

    // Basic find.
    b_clr = clr_cnt;
    add(K_FOUND, 2, 3, t_a5, 1'b0);
    session();
    lit(S_FTAPS, 128'(t_a5), "basic_found_taps");
    lit(S_FOUND, 128'd1, "basic_found");
    lit(S_ATT,   128'd0, "basic_attempts");
    lit(S_CLR,   128'(b_clr + 1), "basic_clear_pulses");

    // Retry: two failures, then found; start pulsed during RUN.
    b_clr = clr_cnt; b_run = run_cyc;
    add(K_FAIL,  1, 2, t1, 1'b1);
    add(K_FAIL,  0, 5, t2, 1'b0);
    add(K_FOUND, 2, 1, t3, 1'b1);
    session();
    lit(S_ATT,   128'd2, "retry_attempts");
    lit(S_FTAPS, 128'(t3), "retry_found_taps");
    lit(S_CLR,   128'(b_clr + 3), "retry_clear_pulses");
    lit(S_RUNC,  128'(b_run + 11), "retry_run_cycles");

    // Exhaustion at MAX_ATTEMPTS = 3.
    b_gen = gen_rise;
    add(K_FAIL, 0, 1, t1, 1'b0);
    add(K_FAIL, 1, 0, t2, 1'b0);
    add(K_FAIL, 0, 2, t3, 1'b0);
    session();
    lit(S_EXH,   128'd1, "exh_exhausted");
    lit(S_FOUND, 128'd0, "exh_found");
    lit(S_ATT,   128'd3, "exh_attempts");
    lit(S_GENR,  128'(b_gen + 3), "exh_gen_phases");

    // Found and failure together: found wins, attempts unchanged.
    add(K_FAIL, 0, 0, t1, 1'b0);
    add(K_BOTH, 0, 3, t2, 1'b0);
    session();
    lit(S_FOUND, 128'd1, "both_found");
    lit(S_ATT,   128'd1, "both_attempts");
    lit(S_FTAPS, 128'(t2), "both_found_taps");

    // Abort in GEN after one failure keeps attempts.
    add(K_FAIL,      0, 1, t1, 1'b0);
    add(K_ABORT_GEN, 2, 0, t2, 1'b0);
    session();
    lit(S_ATT,   128'd1, "abort_gen_attempts");
    lit(S_FOUND, 128'd0, "abort_gen_found");
    lit(S_EXH,   128'd0, "abort_gen_exhausted");

    // Abort in CLEAR; the new start has cleared attempts.
    add(K_ABORT_CLEAR, 0, 0, t1, 1'b0);
    session();
    lit(S_ATT, 128'd0, "abort_clear_attempts");

    // Abort in RUN.
    add(K_ABORT_RUN, 1, 2, t3, 1'b0);
    session();
    lit(S_FOUND, 128'd0, "abort_run_found");

    // Found on the last RUN cycle the watchdog would allow.
    add(K_FOUND, 0, TO - 1, t1, 1'b0);
    session();
    lit(S_FTAPS, 128'(t1), "late_found_taps");

`ifdef SEARCH_TIMEOUT_EN
    // Watchdog: silent RUN of TO cycles acts as a failure, then CLEAR.
    b_clr = clr_cnt; b_run = run_cyc;
    add(K_TIMEOUT, 1, 0, t1, 1'b0);
    add(K_FOUND,   0, 2, t2, 1'b0);
    session();
    lit(S_ATT,   128'd1, "timeout_attempts");
    lit(S_FTAPS, 128'(t2), "timeout_found_taps");
    lit(S_CLR,   128'(b_clr + 2), "timeout_clear_pulses");
    lit(S_RUNC,  128'(b_run + 11), "timeout_run_cycles");
`else
    // No watchdog: RUN waits indefinitely until aborted.
    b_run = run_cyc;
    add(K_ABORT_RUN, 0, 120, t1, 1'b0);
    session();
    lit(S_RUNC, 128'(b_run + 121), "hang_run_cycles");
    lit(S_ATT,  128'd0, "hang_attempts");
`endif

    // Reset in the middle of GEN returns to IDLE with results cleared.
    add(K_FOUND, 0, 1, t1, 1'b0);
    session();
    add(K_RESET, 2, 0, t2, 1'b0);
    session();
    lit(S_FOUND, 128'd0, "midreset_found");
    lit(S_FTAPS, 128'd0, "midreset_found_taps");

    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
